// File: rtl/i2c_pkg.sv
// Shared I2C engine command encodings and register-sequencer types.
package i2c_pkg;

    localparam int unsigned CMD_W  = 6;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DEV_W  = 7;
    localparam int unsigned REG_W  = 16;
    localparam int unsigned STEP_W = 3;

    localparam logic [CMD_W-1:0] CMD_WR   = 6'b000001;
    localparam logic [CMD_W-1:0] CMD_STA  = 6'b000010;
    localparam logic [CMD_W-1:0] CMD_RD   = 6'b000100;
    localparam logic [CMD_W-1:0] CMD_STO  = 6'b001000;
    localparam logic [CMD_W-1:0] CMD_ACK  = 6'b010000;
    localparam logic [CMD_W-1:0] CMD_NACK = 6'b100000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } ctrl_state_e;

    // Sequence steps; S3 is the data byte for writes, the repeated START for reads
    localparam logic [STEP_W-1:0] STEP_DEV = 3'd0;
    localparam logic [STEP_W-1:0] STEP_RHI = 3'd1;
    localparam logic [STEP_W-1:0] STEP_RLO = 3'd2;
    localparam logic [STEP_W-1:0] STEP_S3  = 3'd3;
    localparam logic [STEP_W-1:0] STEP_RD  = 3'd4;

    typedef struct packed {
        logic              rd;
        logic [DEV_W-1:0]  dev;
        logic [REG_W-1:0]  addr;
        logic [BYTE_W-1:0] data;
    } reg_req_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [BYTE_W-1:0] tx;
    } eng_cmd_t;

    // Engine command and byte for one step of a latched request
    function automatic eng_cmd_t step_cmd(input reg_req_t req, input logic [STEP_W-1:0] step);
        eng_cmd_t c;
        c.cmd = CMD_RD | CMD_NACK | CMD_STO;
        c.tx  = '0;
        case (step)
            STEP_DEV: begin
                c.cmd = CMD_STA | CMD_WR;
                c.tx  = {req.dev, 1'b0};
            end
            STEP_RHI: begin
                c.cmd = CMD_WR;
                c.tx  = req.addr[15:8];
            end
            STEP_RLO: begin
                c.cmd = CMD_WR;
                c.tx  = req.addr[7:0];
            end
            STEP_S3: begin
                if (req.rd) begin
                    c.cmd = CMD_STA | CMD_WR;
                    c.tx  = {req.dev, 1'b1};
                end else begin
                    c.cmd = CMD_WR | CMD_STO;
                    c.tx  = req.data;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer: expands one register write/read request into the
// I2C engine's byte-level command stream and reports ACK status and read data.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter bit          ADDR16      = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 200_000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              wrreg_req,
    input  logic              rdreg_req,
    input  logic [DEV_W-1:0]  dev_addr,
    input  logic [REG_W-1:0]  reg_addr,
    input  logic [BYTE_W-1:0] wrdata,
    output logic [BYTE_W-1:0] rddata,
    output logic              RW_Done,
    output logic              ack_err,
    output logic              busy,
    output logic [CMD_W-1:0]  Cmd,
    output logic              Go,
    output logic [BYTE_W-1:0] Tx_DATA,
    input  logic              Trans_Done,
    input  logic              ack_i,
    input  logic [BYTE_W-1:0] Rx_DATA
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    ctrl_state_e       state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic [STEP_W-1:0] last_step;
    logic [WD_W-1:0]   wd, wd_nxt;
    reg_req_t          req, req_nxt;
    eng_cmd_t          issue;
    logic [CMD_W-1:0]  cmd_nxt;
    logic [BYTE_W-1:0] tx_nxt, rddata_nxt;
    logic              err_nxt;

    assign last_step = req.rd ? STEP_RD : STEP_S3;

    // Next-state, step sequencing, watchdog and result capture
    always_comb begin
        state_nxt  = state;
        step_nxt   = step;
        wd_nxt     = wd;
        req_nxt    = req;
        rddata_nxt = rddata;
        err_nxt    = ack_err;
        unique case (state)
            ST_IDLE: begin
                if (wrreg_req || rdreg_req) begin
                    req_nxt   = '{rd: !wrreg_req, dev: dev_addr, addr: reg_addr, data: wrdata};
                    step_nxt  = STEP_DEV;
                    err_nxt   = 1'b0;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Watchdog counts cycles since Go, so an abort lands TIMEOUT_CYC cycles after it
                wd_nxt    = WD_W'(1);
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (Trans_Done) begin
                    if (step == STEP_RD) rddata_nxt = Rx_DATA;
                    else                 err_nxt    = ack_err | ack_i;
                    state_nxt = ST_NEXT;
                end else if (wd >= WD_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            ST_NEXT: begin
                if (step == last_step) begin
                    state_nxt = ST_DONE;
                end else begin
                    step_nxt  = (!ADDR16 && step == STEP_DEV) ? STEP_RLO : step + STEP_W'(1);
                    state_nxt = ST_ISSUE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        // Engine command is loaded on entry to ISSUE and held through WAIT
        issue   = step_cmd(req_nxt, step_nxt);
        cmd_nxt = Cmd;
        tx_nxt  = Tx_DATA;
        if (state_nxt == ST_ISSUE) begin
            cmd_nxt = issue.cmd;
            tx_nxt  = issue.tx;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= ST_IDLE;
            step    <= '0;
            wd      <= '0;
            req     <= '0;
            Cmd     <= '0;
            Tx_DATA <= '0;
            Go      <= 1'b0;
            rddata  <= '0;
            RW_Done <= 1'b0;
            ack_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            step    <= step_nxt;
            wd      <= wd_nxt;
            req     <= req_nxt;
            Cmd     <= cmd_nxt;
            Tx_DATA <= tx_nxt;
            Go      <= (state_nxt == ST_ISSUE);
            rddata  <= rddata_nxt;
            RW_Done <= (state_nxt == ST_DONE);
            ack_err <= err_nxt;
            busy    <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Scoreboard bench for i2c_reg_ctrl: two lanes (16-bit and 8-bit register
// address), each with a behavioural engine model and a reference transaction model.
`timescale 1ns/1ps
module tb_i2c_reg_ctrl;

    localparam int TMO = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit lane_done [2];

    typedef struct {
        logic [5:0] cmd;
        logic [7:0] tx;
        bit         care;
    } exp_cmd_t;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        bit         hang;
    } exp_res_t;

    task automatic chk_eq(input int lane_id, input string name,
                          input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     lane_id, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam bit A16 = (g == 0);

        logic       rst, wr_req, rd_req;
        logic [6:0] dev;
        logic [15:0] raddr;
        logic [7:0] wdata, rddata, tx, rx;
        logic       rw_done, ack_err, busy, go, td, ack;
        logic [5:0] cmd;

        i2c_reg_ctrl #(.ADDR16(A16), .TIMEOUT_CYC(TMO)) dut (
            .Clk(clk), .Rst(rst),
            .wrreg_req(wr_req), .rdreg_req(rd_req),
            .dev_addr(dev), .reg_addr(raddr), .wrdata(wdata),
            .rddata(rddata), .RW_Done(rw_done), .ack_err(ack_err), .busy(busy),
            .Cmd(cmd), .Go(go), .Tx_DATA(tx),
            .Trans_Done(td), .ack_i(ack), .Rx_DATA(rx)
        );

        logic [4:0] nack_mask;
        logic [7:0] rx_val;
        bit         hang, stray_en, pend, td_real, first_pending;
        int         idx, cnt, acc_cyc, first_go_cyc, last_td_cyc;
        logic [5:0] cur_cmd;
        logic [7:0] model_rd;
        logic       model_err;
        exp_cmd_t   cq[$];
        exp_res_t   rq[$];

        // Engine model: answers each Go after 1-4 cycles, or never when hung
        initial begin
            td = 1'b0; ack = 1'b0; rx = '0; pend = 0; cnt = 0; td_real = 0;
            forever begin
                @(negedge clk);
                td = 1'b0; td_real = 0;
                ack = 1'($urandom); rx = 8'($urandom);
                if (rst) begin
                    pend = 0;
                end else begin
                    if (pend) begin
                        if (cnt == 0) begin
                            td = 1'b1; td_real = 1;
                            ack = (idx < 5) ? nack_mask[idx] : 1'b0;
                            rx = rx_val; idx++; pend = 0;
                        end else begin
                            cnt--;
                        end
                    end else if (stray_en && !hang && !go && $urandom_range(0, 9) == 0) begin
                        td = 1'b1; ack = 1'b1;
                    end
                    if (go && !hang) begin
                        pend = 1; cnt = $urandom_range(0, 3);
                    end
                end
            end
        end

        // Monitor: compares every Go command and every completion with the scoreboard
        initial begin
            exp_cmd_t ec;
            exp_res_t er;
            forever begin
                @(posedge clk); #1;
                if (rst) continue;
                if (go) begin
                    if (first_pending) begin
                        chk_eq(g, "first_go_lat", 32'(cyc), 32'(acc_cyc));
                        chk_eq(g, "busy_on", 32'(busy), 32'd1);
                        first_pending = 0;
                        first_go_cyc = cyc;
                    end else begin
                        chk_eq(g, "go_after_done_lat", 32'(cyc), 32'(last_td_cyc + 1));
                    end
                    chk_eq(g, "go_expected", 32'(cq.size() > 0), 32'd1);
                    if (cq.size() > 0) begin
                        ec = cq.pop_front();
                        chk_eq(g, "cmd", 32'(cmd), 32'(ec.cmd));
                        if (ec.care) chk_eq(g, "tx", 32'(tx), 32'(ec.tx));
                    end
                    cur_cmd = cmd;
                end
                if (td_real) begin
                    last_td_cyc = cyc;
                    chk_eq(g, "cmd_hold", 32'(cmd), 32'(cur_cmd));
                end
                if (rw_done) begin
                    chk_eq(g, "done_expected", 32'(rq.size()), 32'd1);
                    chk_eq(g, "cmds_left", 32'(cq.size()), 32'd0);
                    if (rq.size() > 0) begin
                        er = rq.pop_front();
                        chk_eq(g, "ack_err", 32'(ack_err), 32'(er.err));
                        chk_eq(g, "rddata", 32'(rddata), 32'(er.rd));
                        if (er.hang) chk_eq(g, "timeout_lat", 32'(cyc), 32'(first_go_cyc + TMO));
                        else         chk_eq(g, "done_lat", 32'(cyc), 32'(last_td_cyc + 1));
                    end
                end
            end
        end

        task automatic chk_reset_outputs(input string tag);
            chk_eq(g, {tag, "_cmd"},     32'(cmd),     32'd0);
            chk_eq(g, {tag, "_go"},      32'(go),      32'd0);
            chk_eq(g, {tag, "_tx"},      32'(tx),      32'd0);
            chk_eq(g, {tag, "_rddata"},  32'(rddata),  32'd0);
            chk_eq(g, {tag, "_rw_done"}, 32'(rw_done), 32'd0);
            chk_eq(g, {tag, "_ack_err"}, 32'(ack_err), 32'd0);
            chk_eq(g, {tag, "_busy"},    32'(busy),    32'd0);
        endtask

        // Issue one request, record the expected command list and result, wait for completion
        task automatic do_req(input bit w, input bit r, input logic [6:0] d,
                              input logic [15:0] a, input logic [7:0] dat,
                              input logic [4:0] nm, input logic [7:0] rv,
                              input bit h, input bit poke);
            exp_cmd_t seq[$];
            bit is_rd, seen;
            logic err;
            int n_wr;
            @(negedge clk);
            chk_eq(g, "rddata_hold", 32'(rddata), 32'(model_rd));
            chk_eq(g, "ack_err_hold", 32'(ack_err), 32'(model_err));
            chk_eq(g, "idle_busy", 32'(busy), 32'd0);
            is_rd = r && !w;
            seq.push_back('{cmd: 6'h03, tx: {d, 1'b0}, care: 1'b1});
            if (A16) seq.push_back('{cmd: 6'h01, tx: a[15:8], care: 1'b1});
            seq.push_back('{cmd: 6'h01, tx: a[7:0], care: 1'b1});
            if (is_rd) begin
                seq.push_back('{cmd: 6'h03, tx: {d, 1'b1}, care: 1'b1});
                seq.push_back('{cmd: 6'h2C, tx: 8'h00, care: 1'b0});
            end else begin
                seq.push_back('{cmd: 6'h09, tx: dat, care: 1'b1});
            end
            n_wr = is_rd ? seq.size() - 1 : seq.size();
            err = h;
            if (!h) for (int k = 0; k < n_wr; k++) err |= nm[k];
            if (is_rd && !h) model_rd = rv;
            model_err = err;
            if (h) cq.push_back(seq[0]);
            else   foreach (seq[k]) cq.push_back(seq[k]);
            rq.push_back('{rd: model_rd, err: err, hang: h});
            nack_mask = nm; rx_val = rv; hang = h; idx = 0;
            acc_cyc = cyc + 1; first_pending = 1;
            wr_req = w; rd_req = r; dev = d; raddr = a; wdata = dat;
            @(negedge clk);
            wr_req = 1'b0; rd_req = 1'b0;
            dev = 7'($urandom); raddr = 16'($urandom); wdata = 8'($urandom);
            if (poke) begin
                repeat (2) @(negedge clk);
                chk_eq(g, "busy_mid", 32'(busy), 32'd1);
                wr_req = 1'($urandom); rd_req = 1'b1;
                @(negedge clk);
                wr_req = 1'b0; rd_req = 1'b0;
            end
            seen = 0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                if (rw_done) seen = 1;
            end
            chk_eq(g, "done_seen", 32'(seen), 32'd1);
        endtask

        // Park the DUT in WAIT on a hung engine, then reset it
        task automatic reset_mid_wait();
            @(negedge clk);
            hang = 1; idx = 0; acc_cyc = cyc + 1; first_pending = 1;
            cq.push_back('{cmd: 6'h03, tx: {7'h2A, 1'b0}, care: 1'b1});
            wr_req = 1'b1; dev = 7'h2A; raddr = 16'h1111; wdata = 8'h22;
            @(negedge clk);
            wr_req = 1'b0;
            repeat (4) @(negedge clk);
            chk_eq(g, "busy_pre_rst", 32'(busy), 32'd1);
            rst = 1'b1;
            #1;
            chk_reset_outputs("rst_mid");
            cq.delete(); rq.delete();
            first_pending = 0; model_rd = '0; model_err = 1'b0;
            @(negedge clk);
            rst = 1'b0; hang = 0;
        endtask

        initial begin
            bit w, r;
            rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; dev = '0; raddr = '0; wdata = '0;
            nack_mask = '0; rx_val = '0; hang = 0; stray_en = 0; idx = 0;
            first_pending = 0; model_rd = '0; model_err = 1'b0; cur_cmd = '0;
            acc_cyc = 0; first_go_cyc = 0; last_td_cyc = 0;
            repeat (3) @(negedge clk);
            chk_reset_outputs("por");
            rst = 1'b0;
            do_req(1, 0, 7'h3C, 16'h3008, 8'h82, 5'b00000, 8'h00, 0, 0);
            do_req(0, 1, 7'h3C, 16'h300A, 8'h00, 5'b00000, 8'h56, 0, 0);
            do_req(1, 0, 7'h3C, 16'h1234, 8'h55, 5'b00010, 8'h00, 0, 0);
            do_req(0, 1, 7'h21, 16'hBEEF, 8'h00, 5'b10000, 8'hA5, 0, 0);
            do_req(0, 1, 7'h3C, 16'h0001, 8'h00, 5'b00000, 8'h77, 1, 0);
            do_req(1, 1, 7'h44, 16'h5678, 8'h99, 5'b00000, 8'h11, 0, 0);
            do_req(1, 0, 7'h50, 16'hA5A5, 8'h3C, 5'b00000, 8'h00, 0, 1);
            reset_mid_wait();
            do_req(0, 1, 7'h12, 16'h0F0F, 8'h00, 5'b00000, 8'hC3, 0, 0);
            stray_en = 1;
            for (int t = 0; t < 30; t++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                w = 1'($urandom);
                r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
                do_req(w, r, 7'($urandom), 16'($urandom), 8'($urandom),
                       ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000,
                       8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            end
            repeat (3) @(negedge clk);
            lane_done[g] = 1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(lane_done[0] && lane_done[1]) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (!(lane_done[0] && lane_done[1])) begin
            errors++;
            $display("FAIL sim_timeout: lanes done %0d/%0d after %0d cycles",
                     lane_done[0], lane_done[1], n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Register-access sequencer that sits above the I2C bit-shift engine and turns one single-register write or read request into the engine's byte-level command stream. Per request it issues START, device-address, register-address, data, optional repeated-START and STOP commands one byte at a time. It drives `Cmd`/`Go`/`Tx_DATA` and waits for each `Trans_Done`. It also collects slave ACK status and the read byte, and returns a one-cycle completion pulse to the configuration front end (sensor/codec init tables).

## Interface
- `ADDR16`, default 1: 1 = 16-bit register address (hi byte then lo byte); 0 = 8-bit (lo byte only).
- `TIMEOUT_CYC`, default 200_000: maximum Clk cycles to wait for one `Trans_Done` before aborting.

Ports:
- `Clk`  in  1  system clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `wrreg_req`  in  1  one-cycle request: write `wrdata` to `reg_addr`.
- `rdreg_req`  in  1  one-cycle request: read `reg_addr`.
- `dev_addr`  in  7  7-bit slave address; sampled with the request.
- `reg_addr`  in  16  register address; sampled with the request.
- `wrdata`  in  8  write byte; sampled with the request.
- `rddata`  out  8  read result; valid when `RW_Done` pulses after a read.
- `RW_Done`  out  1  one-cycle completion pulse.
- `ack_err`  out  1  set if any slave ACK slot returned 1 (NACK) or on timeout; valid with `RW_Done`.
- `busy`  out  1  high from the accepted request until `RW_Done`.
- `Cmd`  out  6  to engine, one-hot OR of WR/STA/RD/STO/ACK/NACK.
- `Go`  out  1  to engine, one-cycle start.
- `Tx_DATA`  out  8  to engine, byte to send.
- `Trans_Done`  in  1  from engine, byte-command complete.
- `ack_i`  in  1  from engine, sampled ACK bit (0 = ACK).
- `Rx_DATA`  in  8  from engine, received byte.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT`, `NEXT`, `DONE`.
- `IDLE`
  - On `wrreg_req` or `rdreg_req`: latch `dev_addr`, `reg_addr`, `wrdata` and the op, then go to `ISSUE`.
  - If both requests are high in the same cycle, write wins and the read is dropped.
  - Clear `ack_err` on accept.
- A step counter selects the command. The step is skipped when `ADDR16`=0.
- Write sequence:
  - S0: `STA|WR`, `{dev,0}`
  - S1: `WR`, `reg[15:8]`
  - S2: `WR`, `reg[7:0]`
  - S3: `WR|STO`, `wrdata`
- Read sequence:
  - S0: `STA|WR`, `{dev,0}`
  - S1: `WR`, `reg[15:8]`
  - S2: `WR`, `reg[7:0]`
  - S3: `STA|WR`, `{dev,1}` (repeated START)
  - S4: `RD|NACK|STO`
- `ISSUE`: drive `Cmd`/`Tx_DATA` for the current step, pulse `Go` for one cycle, go to `WAIT`.
- `WAIT`
  - Hold `Cmd` and `Tx_DATA` stable; the engine reads `Cmd` throughout the byte.
  - On `Trans_Done`:
    - For WR steps, OR `ack_i` into `ack_err`.
    - For the RD step, latch `Rx_DATA` into `rddata`.
  - Then go to `NEXT`.
- `NEXT`: on the last step go to `DONE`; otherwise advance the step and go to `ISSUE`.
- Slave NACK does not abort; the sequence always runs to STOP so the bus is released.
- Timeout
  - The watchdog counts in `WAIT` and resets on every `ISSUE`.
  - On reaching `TIMEOUT_CYC`-1: set `ack_err` and go to `DONE` without further commands.
- `DONE`: pulse `RW_Done` for one cycle, clear `busy`, return to `IDLE`.
- Requests while `busy` are ignored (not queued).

## Timing
- Reset values:
  - `Cmd`=0, `Go`=0, `Tx_DATA`=0
  - `rddata`=0, `RW_Done`=0, `ack_err`=0, `busy`=0
  - state `IDLE`, step 0, watchdog 0
- Reset mid-transaction returns to `IDLE` at once. No STOP is generated; bus recovery belongs to the caller.
- Request accepted in cycle N:
  - `busy`=1 from N+1.
  - First `Go` at N+1.
- `Trans_Done` in cycle M gives the next `Go` at M+2 (`NEXT`, then `ISSUE`).
- `RW_Done` is 2 cycles after the final `Trans_Done`.
- `rddata` and `ack_err` are stable from the `RW_Done` cycle until the next accepted request.
- `Go` is never asserted in `WAIT`. `Trans_Done` outside `WAIT` is ignored.

## Structure
- Shared package `i2c_pkg` holds:
  - `CMD_WR`=6'b000001, `CMD_STA`=6'b000010, `CMD_RD`=6'b000100, `CMD_STO`=6'b001000, `CMD_ACK`=6'b010000, `CMD_NACK`=6'b100000
  - the controller state encoding
- The block instantiates no engine. A top-level `i2c_ctrl_top` wires this block to the bit-shift engine.
- The timeout counter is inline; no sub-module is needed.

## Test plan
- Write, `ADDR16`=1, dev=0x3C, reg=0x3008, data=0x82, engine model always ACKs:
  - exactly 4 Go pulses.
  - Cmd/Tx: 0x03/0x78, 0x01/0x30, 0x01/0x08, 0x09/0x82.
  - `RW_Done` pulses once with `ack_err`=0.
- Read, `ADDR16`=1, dev=0x3C, reg=0x300A, model returns 0x56:
  - 5 commands, the last two being 0x03/0x79 and 0x2C.
  - `rddata`=0x56, `ack_err`=0.
- `ADDR16`=0 write:
  - only 3 Go pulses.
  - reg hi byte never sent.
- Model NACKs the second byte:
  - the sequence still finishes with the STO command.
  - `ack_err`=1 at `RW_Done`.
- Model never returns `Trans_Done`, `TIMEOUT_CYC`=50:
  - `RW_Done` with `ack_err`=1, 50 cycles after the first `Go`.
- Overlap and reset:
  - `wrreg_req` and `rdreg_req` in the same cycle gives a write sequence.
  - A request during `busy` is ignored.
  - `Rst` asserted mid-`WAIT`: all outputs go to reset values and the next request starts at S0.
